// File: rtl/match_scheduler.sv
`timescale 1ns/1ps
// match_scheduler
//
// Runs template matching over a fully buffered utterance. When `start` is
// accepted, every stored template is visited in turn. For each one the block
// sweeps both memories in lockstep and sums the absolute sample differences
// (SAD). The lowest SAD wins, and ties go to the lower template index. The
// winning index and score are published together with a threshold-qualified
// match flag.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   start        request a run (accepted only while idle)
//   thresh       acceptance threshold, captured when start is accepted
//   audio_addr   audio buffer read address
//   audio_data   audio buffer read data (1-cycle latency)
//   tmpl_idx     template select
//   tmpl_addr    template sample address
//   tmpl_data    template read data (1-cycle latency)
//   busy         high from the cycle after start is accepted through DONE
//   done         one-cycle pulse in the cycle the results update
//   best_idx     index of the lowest-SAD template
//   best_score   SAD of best_idx
//   match        best_score < captured thresh
module match_scheduler #(
  parameter int N_SAMPLES   = 1000,
  parameter int N_TEMPLATES = 4,
  parameter int SAMPLE_W    = 10,
  parameter int ACC_W       = 20,
  localparam int AW = (N_SAMPLES   > 1) ? $clog2(N_SAMPLES)   : 1,
  localparam int IW = (N_TEMPLATES > 1) ? $clog2(N_TEMPLATES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ACC_W-1:0]    thresh,
  output logic [AW-1:0]       audio_addr,
  input  logic [SAMPLE_W-1:0] audio_data,
  output logic [IW-1:0]       tmpl_idx,
  output logic [AW-1:0]       tmpl_addr,
  input  logic [SAMPLE_W-1:0] tmpl_data,
  output logic                busy,
  output logic                done,
  output logic [IW-1:0]       best_idx,
  output logic [ACC_W-1:0]    best_score,
  output logic                match
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CMP, S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_SAMPLES - 1);
  localparam logic [IW-1:0] LAST_TMPL = IW'(N_TEMPLATES - 1);

  state_t               state;
  logic [AW-1:0]        addr;        // shared by both memories (lockstep)
  logic                 valid;       // read data on the buses belongs to this run
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     thresh_q;
  logic [ACC_W-1:0]     work_score;
  logic [IW-1:0]        work_idx;

  logic [SAMPLE_W-1:0]  diff;
  logic                 better;
  logic [ACC_W-1:0]     next_score;
  logic [IW-1:0]        next_idx;

  assign audio_addr = addr;
  assign tmpl_addr  = addr;

  // NOTE: each always_comb output gets a value on every path (here via the
  // ternaries), so no latch can be inferred.
  always_comb begin
    diff       = (audio_data > tmpl_data) ? (audio_data - tmpl_data)
                                          : (tmpl_data - audio_data);
    // Strict compare: on a tie the earlier (lower-index) template is kept.
    better     = (acc < work_score);
    next_score = better ? acc      : work_score;
    next_idx   = better ? tmpl_idx : work_idx;
  end

  // NOTE: all state is updated with non-blocking assignments so that each
  // branch reads the values from before this edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      valid      <= 1'b0;
      acc        <= '0;
      thresh_q   <= '0;
      work_score <= '1;
      work_idx   <= '0;
      tmpl_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      best_idx   <= '0;
      best_score <= '1;
      match      <= 1'b0;
    end else begin
      done  <= 1'b0;
      // Data for an address issued in RUN arrives one cycle later. That can
      // be during RUN itself or in DRAIN for the final address.
      valid <= (state == S_RUN);
      if (valid) acc <= acc + ACC_W'(diff);

      unique case (state)
        S_IDLE: begin
          if (start) begin
            thresh_q   <= thresh;
            tmpl_idx   <= '0;
            work_score <= '1;
            work_idx   <= '0;
            addr       <= '0;
            busy       <= 1'b1;
            state      <= S_CLR;
          end
        end

        S_CLR: begin
          acc   <= '0;
          addr  <= '0;
          state <= S_RUN;
        end

        S_RUN: begin
          // The address holds at the last sample instead of wrapping.
          if (addr == LAST_ADDR) state <= S_DRAIN;
          else                   addr  <= addr + 1'b1;
        end

        S_DRAIN: state <= S_CMP;

        S_CMP: begin
          work_score <= next_score;
          work_idx   <= next_idx;
          if (tmpl_idx == LAST_TMPL) begin
            // The results are published on entry to DONE. They are then
            // visible in the same cycle that done is high.
            best_score <= next_score;
            best_idx   <= next_idx;
            match      <= (next_score < thresh_q);
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            tmpl_idx <= tmpl_idx + 1'b1;
            addr     <= '0;
            state    <= S_CLR;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
`timescale 1ns/1ps
module tb_match_scheduler;

  localparam int N_SAMPLES   = 4;
  localparam int N_TEMPLATES = 3;
  localparam int SAMPLE_W    = 10;
  localparam int ACC_W       = 20;
  localparam int RUN_EDGES   = 21;  // edges from the start edge to done visible

  typedef logic [3:0][9:0] row_t;

  typedef struct {
    string            name;
    row_t             audio;
    row_t [2:0]       tmpl;
    logic [ACC_W-1:0] thresh;
    logic [1:0]       exp_idx;
    logic [ACC_W-1:0] exp_score;
    logic             exp_match;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [ACC_W-1:0] thresh;
  logic [1:0]       audio_addr;
  logic [9:0]       audio_data;
  logic [1:0]       tmpl_idx;
  logic [1:0]       tmpl_addr;
  logic [9:0]       tmpl_data;
  logic             busy;
  logic             done;
  logic [1:0]       best_idx;
  logic [ACC_W-1:0] best_score;
  logic             match;

  row_t       cur_audio;
  row_t [2:0] cur_tmpl;

  int checks = 0;
  int errors = 0;

  match_scheduler #(
    .N_SAMPLES(N_SAMPLES), .N_TEMPLATES(N_TEMPLATES),
    .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .thresh(thresh),
    .audio_addr(audio_addr), .audio_data(audio_data),
    .tmpl_idx(tmpl_idx), .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data),
    .busy(busy), .done(done), .best_idx(best_idx),
    .best_score(best_score), .match(match)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories with exactly one cycle of latency.
  always @(posedge clk) begin
    audio_data <= cur_audio[audio_addr];
    tmpl_data  <= cur_tmpl[tmpl_idx][tmpl_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic row_t mk4(input int a0, input int a1, input int a2, input int a3);
    row_t r;
    r[0] = 10'(a0); r[1] = 10'(a1); r[2] = 10'(a2); r[3] = 10'(a3);
    return r;
  endfunction

  task automatic load(input vec_t v);
    cur_audio = v.audio;
    cur_tmpl  = v.tmpl;
    thresh    = v.thresh;
  endtask

  // Pulses start for the edge that follows, then leaves the bench just after that edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int edges;
    @(negedge clk);
    load(v);
    pulse_start();
    check({v.name, " busy_after_start"}, busy, 1);
    edges = 0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check({v.name, " done_latency"}, edges, RUN_EDGES);
    check({v.name, " best_idx"}, best_idx, v.exp_idx);
    check({v.name, " best_score"}, best_score, v.exp_score);
    check({v.name, " match"}, match, v.exp_match);
    check({v.name, " busy_in_done"}, busy, 1);
    @(posedge clk);
    #1;
    check({v.name, " done_pulse_end"}, done, 0);
    check({v.name, " busy_fall"}, busy, 0);
  endtask

  vec_t vecs[7];

  initial begin
    int  done_cnt;
    int  done_cyc[2];
    bit  exp_busy;
    int  c;

    vecs[0] = '{"basic", mk4(10,20,30,40),
                {mk4(12,20,30,40), mk4(10,20,30,41), mk4(0,0,0,0)},
                20'd5, 2'd1, 20'd1, 1'b1};
    vecs[1] = '{"tie_th1", mk4(10,20,30,40),
                {mk4(10,20,30,40), mk4(0,0,0,0), mk4(10,20,30,40)},
                20'd1, 2'd0, 20'd0, 1'b1};
    vecs[2] = '{"tie_th0", mk4(10,20,30,40),
                {mk4(10,20,30,40), mk4(0,0,0,0), mk4(10,20,30,40)},
                20'd0, 2'd0, 20'd0, 1'b0};
    vecs[3] = '{"max_a", mk4(1023,1023,1023,1023),
                {mk4(0,0,0,0), mk4(0,0,0,0), mk4(0,0,0,0)},
                20'd5000, 2'd0, 20'd4092, 1'b1};
    vecs[4] = '{"max_b_thresh_eq", mk4(0,0,0,0),
                {mk4(1023,1023,1023,1023), mk4(1023,1023,1023,1023), mk4(1023,1023,1023,1023)},
                20'd4092, 2'd0, 20'd4092, 1'b0};
    vecs[5] = '{"last_wins", mk4(1,2,3,4),
                {mk4(1,2,3,5), mk4(0,0,0,0), mk4(5,5,5,5)},
                20'd2, 2'd2, 20'd1, 1'b1};
    vecs[6] = '{"tie_mid", mk4(100,200,300,400),
                {mk4(100,200,300,399), mk4(101,200,300,400), mk4(0,0,0,0)},
                20'd1, 2'd1, 20'd1, 1'b0};

    reset = 1'b1; start = 1'b0; thresh = '0;
    cur_audio = '0; cur_tmpl = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst match", match, 0);
    check("rst best_idx", best_idx, 0);
    check("rst best_score", best_score, 20'hFFFFF);
    check("rst tmpl_idx", tmpl_idx, 0);
    check("rst audio_addr", audio_addr, 0);
    check("rst tmpl_addr", tmpl_addr, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Address sweep: phase p within each template is CLR, RUN x4, DRAIN, CMP.
    @(negedge clk);
    load(vecs[0]);
    pulse_start();
    for (int cy = 1; cy <= 22; cy++) begin
      int p;
      int exp_a;
      p = (cy - 1) % 7;
      exp_a = (p == 0) ? 0 : (p <= 4) ? p - 1 : 3;
      if (cy <= 21) begin
        check($sformatf("sweep audio_addr c%0d", cy), audio_addr, exp_a);
        check($sformatf("sweep tmpl_addr c%0d", cy), tmpl_addr, exp_a);
        check($sformatf("sweep tmpl_idx c%0d", cy), tmpl_idx, (cy - 1) / 7);
      end
      if (cy < 22) begin
        @(posedge clk);
        #1;
      end
    end
    check("sweep done", done, 1);
    @(posedge clk);
    #1;

    // Start during busy: starts sampled at edges 0, 5, 22 and 24.
    // Edge e's outputs form cycle e+1.
    @(negedge clk);
    load(vecs[0]);
    done_cnt = 0;
    done_cyc[0] = -1;
    done_cyc[1] = -1;
    for (int e = 0; e <= 50; e++) begin
      @(negedge clk);
      if (e == 23) load(vecs[5]);
      start = (e == 0 || e == 5 || e == 22 || e == 24);
      @(posedge clk);
      #1;
      c = e + 1;
      if (done) begin
        if (done_cnt < 2) done_cyc[done_cnt] = c;
        done_cnt++;
      end
      exp_busy = (c >= 1 && c <= 22) || (c >= 25 && c <= 46);
      check($sformatf("overlap busy c%0d", c), busy, exp_busy);
      if (c >= 22 && c <= 45) check($sformatf("overlap hold c%0d", c), best_idx, 1);
      if (c >= 46) check($sformatf("overlap new c%0d", c), best_idx, 2);
    end
    @(negedge clk);
    start = 1'b0;
    check("overlap done count", done_cnt, 2);
    check("overlap first done", done_cyc[0], 22);
    check("overlap second done", done_cyc[1], 46);

    // Reset mid-run: start at edge 0, reset sampled at edge 10, restart at edge 12.
    load(vecs[0]);
    done_cnt = 0;
    done_cyc[0] = -1;
    for (int e = 0; e <= 40; e++) begin
      @(negedge clk);
      start = (e == 0 || e == 12);
      reset = (e == 10);
      @(posedge clk);
      #1;
      c = e + 1;
      if (done) begin
        if (done_cnt == 0) done_cyc[0] = c;
        done_cnt++;
      end
      if (c == 11) begin
        check("midrst busy", busy, 0);
        check("midrst best_score", best_score, 20'hFFFFF);
        check("midrst best_idx", best_idx, 0);
        check("midrst done_cnt", done_cnt, 0);
      end
      if (c == 34) begin
        check("midrst rerun best_idx", best_idx, 1);
        check("midrst rerun best_score", best_score, 1);
        check("midrst rerun match", match, 1);
      end
    end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("midrst done count", done_cnt, 1);
    check("midrst done cycle", done_cyc[0], 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
